// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX serializer among NUM_REQ byte producers.
// Grants one byte at a time, pulses tx_start, waits for tx_done (or a timeout),
// then holds a guard gap before the next grant.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req, data_in  per-requester pending flag and flattened bytes (req i -> [8i+7:8i])
//   ack           one-cycle one-hot pulse: byte of requester i taken
//   tx_start      one-cycle start pulse to the serializer
//   tx_data       byte to the serializer, held through the frame
//   tx_done       end-of-stop-bit pulse from the serializer
//   owner, busy   current grantee, high whenever not idle
//   timeout_err   one-cycle pulse on an abandoned frame
//   err_cnt       saturating timeout count
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | no frame; arbitrate among pending requests
// ISSUE     | tx_start and ack asserted for this single cycle
// WAIT_DONE | serializer running; watch tx_done and timeout
// GUARD     | idle gap before the next grant
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GUARD_CYCLES   = 2604,
  parameter int TIMEOUT_CYCLES = 30000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       data_in,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [7:0]                 err_cnt
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYCLES - 1);
  // Decided one cycle early because timeout_err is registered: the pulse then
  // lands TIMEOUT_CYCLES after the ISSUE cycle, together with entry into GUARD.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GUARD} state_t;

  state_t            state, state_nxt;
  logic [15:0]       timer, timer_nxt;
  logic [IW-1:0]     last, last_nxt;
  logic [IW-1:0]     winner;
  logic [IW-1:0]     owner_nxt;
  logic [7:0]        tx_data_nxt;
  logic              tx_start_nxt;
  logic [NUM_REQ-1:0] ack_nxt;
  logic              busy_nxt;
  logic              timeout_err_nxt;
  logic [7:0]        err_cnt_nxt;

  // Scan from farthest to nearest so the nearest asserted request after
  // `last` is the one left in winner.
  always_comb begin
    int sum;
    sum    = 0;
    winner = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      sum = int'(last) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      if (req[IW'(sum)]) winner = IW'(sum);
    end
  end

  always_comb begin
    state_nxt       = state;
    timer_nxt       = timer + 16'd1;
    last_nxt        = last;
    owner_nxt       = owner;
    tx_data_nxt     = tx_data;
    tx_start_nxt    = 1'b0;
    ack_nxt         = '0;
    timeout_err_nxt = 1'b0;
    err_cnt_nxt     = err_cnt;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (|req) begin
          state_nxt       = ISSUE;
          owner_nxt       = winner;
          last_nxt        = winner;
          tx_data_nxt     = data_in[{winner, 3'b000} +: 8];
          tx_start_nxt    = 1'b1;
          ack_nxt[winner] = 1'b1;
        end
      end
      ISSUE: begin
        state_nxt = WAIT_DONE;
        timer_nxt = '0;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          state_nxt = GUARD;
          timer_nxt = '0;
        end else if (timer == TIMEOUT_LAST) begin
          state_nxt       = GUARD;
          timer_nxt       = '0;
          timeout_err_nxt = 1'b1;
          err_cnt_nxt     = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
        end
      end
      GUARD: begin
        if (timer == GUARD_LAST) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      last        <= IW'(NUM_REQ - 1);
      owner       <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      ack         <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      err_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      last        <= last_nxt;
      owner       <= owner_nxt;
      tx_data     <= tx_data_nxt;
      tx_start    <= tx_start_nxt;
      ack         <= ack_nxt;
      busy        <= busy_nxt;
      timeout_err <= timeout_err_nxt;
      err_cnt     <= err_cnt_nxt;
    end
  end

endmodule
